// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared CDB types: ROB tag width, CDB_DATA broadcast and FU_RESULT queue entry.
// Tag 0 is reserved as the idle marker because the ROB allocates tags from 1.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package sys_defs;

  localparam int CDB_XLEN = 32;

  localparam logic [`ROB_TAG_LEN:0] CDB_IDLE_TAG = '0;

  typedef struct packed {
    logic [`ROB_TAG_LEN:0] rob_tag;
    logic [CDB_XLEN-1:0]   value;
  } CDB_DATA;

  typedef struct packed {
    logic [`ROB_TAG_LEN:0] rob_tag;
    logic [CDB_XLEN-1:0]   value;
  } FU_RESULT;

endpackage

// File: rtl/cdb_result_fifo.sv
// rtl/cdb_result_fifo.sv - per-FU result queue with extra-MSB wrap pointers and synchronous flush.
module cdb_result_fifo
  import sys_defs::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  FU_RESULT push_data,
  input  logic     pop,
  output FU_RESULT head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  FU_RESULT    mem_q [FIFO_DEPTH];
  logic        do_push;
  logic        do_pop;

  // Equal low bits with differing MSBs means the writer has lapped the reader.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB producer over NUM_FU buffered result ports.
// Optional CDB_BYPASS_EN lets a granted FU with an empty queue drive the bus directly.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = CDB_XLEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU-1:0][`ROB_TAG_LEN:0] fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
  output logic [NUM_FU-1:0]                fu_ready,
  output CDB_DATA                          cdb
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] tag_ok;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant_oh;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] bypass_sel;
  FU_RESULT          head   [NUM_FU];
  FU_RESULT          in_res [NUM_FU];
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     grant;
  logic              grant_vld;
  int                idx;
  CDB_DATA           cdb_q, cdb_d;

  // Readiness comes only from queue occupancy so producers never see a grant-dependent ready.
  assign fu_ready = ~full;
  assign cdb      = cdb_q;

  always_comb begin
    tag_ok = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      tag_ok[i] = fu_valid[i] && (fu_tag[i] != CDB_IDLE_TAG);
    end
  end

`ifdef CDB_BYPASS_EN
  assign req = ~empty | (empty & tag_ok);
`else
  assign req = ~empty;
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant     = PW'(idx);
      end
    end
  end

  assign grant_oh = grant_vld ? (NUM_FU'(1) << grant) : '0;
  assign pop      = grant_oh & ~empty;

`ifdef CDB_BYPASS_EN
  assign bypass_sel = grant_oh & empty;
`else
  assign bypass_sel = '0;
`endif

  assign push = tag_ok & ~bypass_sel;

  always_comb begin
    cdb_d = '0;
    rr_d  = rr_q;
    if (grant_vld) begin
      if (pop[grant]) begin
        cdb_d.rob_tag = head[grant].rob_tag;
        cdb_d.value   = head[grant].value;
      end else begin
        cdb_d.rob_tag = fu_tag[grant];
        cdb_d.value   = fu_value[grant];
      end
      rr_d = (int'(grant) == NUM_FU - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_q <= '0;
      rr_q  <= '0;
    end else if (flush) begin
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
      rr_q  <= rr_d;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign in_res[g].rob_tag = fu_tag[g];
    assign in_res[g].value   = fu_value[g];

    cdb_result_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (push[g]),
      .push_data(in_res[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-level model.
module tb_cdb_arbiter;
  import sys_defs::*;

  localparam int NFU   = 4;
  localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [NFU-1:0]                 fu_valid;
  logic [NFU-1:0]                 fu_ready;
  logic [NFU-1:0][`ROB_TAG_LEN:0] fu_tag;
  logic [NFU-1:0][CDB_XLEN-1:0]   fu_value;
  CDB_DATA cdb;

  int passed = 0;
  int total  = 0;

  logic [37:0] mq [NFU][$];
  int          m_rr;
  logic [5:0]  exp_tag;
  logic [31:0] exp_val;
  int          seen [$];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NFU), .FIFO_DEPTH(DEPTH), .XLEN(CDB_XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .fu_valid(fu_valid),
    .fu_tag  (fu_tag),
    .fu_value(fu_value),
    .fu_ready(fu_ready),
    .cdb     (cdb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [NFU-1:0] model_ready();
    logic [NFU-1:0] r;
    for (int i = 0; i < NFU; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NFU; i++) mq[i].delete();
    m_rr = 0; exp_tag = '0; exp_val = '0;
  endtask

  // Applies one clock edge of the bus rules to the per-FU queues.
  task automatic model_edge();
    logic [NFU-1:0] rdy;
    int g, byp, idx;
    bit live;
    rdy = model_ready();
    g = -1; byp = -1;
    if (flush) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
      exp_tag = '0; exp_val = '0;
    end else begin
      for (int k = 0; k < NFU; k++) begin
        idx  = (m_rr + k) % NFU;
        live = fu_valid[idx] && (fu_tag[idx] != 0);
        if (g < 0 && (mq[idx].size() > 0 || (BYP && live))) g = idx;
      end
      if (g < 0) begin
        exp_tag = '0; exp_val = '0;
      end else begin
        if (mq[g].size() > 0) {exp_tag, exp_val} = mq[g].pop_front();
        else begin
          exp_tag = fu_tag[g]; exp_val = fu_value[g]; byp = g;
        end
        m_rr = (g + 1) % NFU;
      end
      for (int i = 0; i < NFU; i++)
        if (fu_valid[i] && fu_tag[i] != 0 && rdy[i] && i != byp)
          mq[i].push_back({fu_tag[i], fu_value[i]});
    end
  endtask

  task automatic cycle();
    check("fu_ready", fu_ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    check("cdb_tag", cdb.rob_tag, exp_tag);
    check("cdb_value", cdb.value, exp_val);
    if (cdb.rob_tag != 0) seen.push_back(int'(cdb.rob_tag));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_tag = '0; fu_value = '0; flush = 1'b0;
  endtask

  task automatic drive(input int i, input int tag, input int val);
    fu_valid[i] = 1'b1; fu_tag[i] = 6'(tag); fu_value[i] = 32'(val);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  int hits;
  int j1, j0, j2;
  int fu1_tags [$];
  bit saw_low;

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    check("reset_tag", cdb.rob_tag, 0);
    check("reset_value", cdb.value, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("ready_after_reset", fu_ready, 4'b1111);
    @(negedge clk);

    // Single result
    drive(0, 1, 5);
    cycle();
    idle_inputs();
    idle_cycles(3);
    check("single_count", seen.size(), 1);
    check("single_tag", seen[0], 1);
    seen.delete();

    // Steer the pointer back to 0 via FU3, then three-way contention
    drive(3, 12, 77); cycle(); idle_inputs(); idle_cycles(2);
    seen.delete();
    drive(0, 2, 10); drive(1, 3, 20); drive(2, 4, 30);
    cycle(); idle_inputs(); idle_cycles(4);
    check("cont_count", seen.size(), 3);
    check("cont_first", seen[0], 2);
    check("cont_second", seen[1], 3);
    check("cont_third", seen[2], 4);
    seen.delete();
    // Pointer at 3 means FU3 wins over FU0 next
    drive(0, 13, 1); drive(3, 14, 2);
    cycle(); idle_inputs(); idle_cycles(3);
    check("ptr_probe_first", seen[0], 14);
    check("ptr_probe_second", seen[1], 13);
    seen.delete();

    // Backpressure: FU1 sends 5,6,7 while FU0 and FU2 compete
    j0 = 0; j1 = 0; j2 = 0; saw_low = 0;
    for (int c = 0; c < 40 && (j1 < 3 || j0 < 6 || j2 < 6); c++) begin
      logic [NFU-1:0] r;
      idle_inputs();
      if (j0 < 6) drive(0, 20 + j0, c);
      if (j1 < 3) drive(1, 5 + j1, 100 + c);
      if (j2 < 6) drive(2, 40 + j2, 200 + c);
      r = fu_ready;
      if (!r[1]) saw_low = 1;
      cycle();
      if (j0 < 6 && r[0]) j0++;
      if (j1 < 3 && r[1]) j1++;
      if (j2 < 6 && r[2]) j2++;
    end
    idle_inputs(); idle_cycles(8);
    check("bp_ready_dropped", saw_low, 1);
    foreach (seen[k]) if (seen[k] >= 5 && seen[k] <= 7) fu1_tags.push_back(seen[k]);
    check("bp_fu1_count", fu1_tags.size(), 3);
    for (int k = 0; k < 3 && k < fu1_tags.size(); k++) check("bp_fu1_order", fu1_tags[k], 5 + k);
    check("bp_total", seen.size(), 15);
    seen.delete();

    // Flush with a same-edge enqueue
    drive(0, 15, 1); drive(1, 16, 2); drive(2, 17, 3);
    cycle();
    idle_inputs(); flush = 1'b1; drive(3, 8, 88);
    cycle();
    idle_inputs();
    check("flush_ready", fu_ready, 4'b1111);
    idle_cycles(4);
    hits = 0;
    foreach (seen[k]) if (seen[k] == 8 || (seen[k] >= 15 && seen[k] <= 17)) hits++;
    check("flush_leak", hits, BYP ? 1 : 0);
    seen.delete();

    // Tag 0 is ignored
    drive(2, 0, 99); cycle(); idle_inputs(); idle_cycles(3);
    check("tag0_no_bcast", seen.size(), 0);

    // Earliest appearance of a lone result
    drive(3, 9, 50); cycle(); idle_inputs();
`ifdef CDB_BYPASS_EN
    check("bypass_tag", cdb.rob_tag, 9);
    check("bypass_value", cdb.value, 50);
`else
    cycle();
    check("lone_tag", cdb.rob_tag, 9);
    check("lone_value", cdb.value, 50);
`endif
    idle_cycles(2);
    seen.delete();

    // Asynchronous reset while the bus and queues hold data
    drive(1, 11, 1); drive(2, 18, 2); drive(3, 10, 60);
    cycle(); idle_inputs();
`ifndef CDB_BYPASS_EN
    cycle();
`endif
    #2 reset = 1'b0;
    #1;
    check("async_reset_tag", cdb.rob_tag, 0);
    check("async_reset_value", cdb.value, 0);
    model_reset();
    seen.delete();
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(4);
    check("reset_drops_pending", seen.size(), 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      for (int i = 0; i < NFU; i++)
        if ($urandom_range(0, 1) == 1) drive(i, $urandom_range(0, 31), $urandom);
      flush = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle_inputs();
    idle_cycles(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
